// File: rtl/net_packet_decoder_pkg.sv
// Shared definitions for the network packet decoder: packet layout, opcodes,
// decoder states and the widths the decoder slices packets into.
package net_packet_decoder_pkg;

    localparam int net_id_width_gp   = 10;
    localparam int net_addr_width_gp = 10;
    localparam int instr_length      = 16;
    localparam int rs_imm_size_gp    = 6;
    localparam int mask_length_gp    = 16;

    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [net_id_width_gp-1:0]   net_id;
        net_op_e                      net_op;
        logic [net_addr_width_gp-1:0] net_addr;
        logic [31:0]                  net_data;
    } net_packet_s;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } decoder_state_e;

    function automatic logic id_matches(input net_packet_s pkt,
                                        input logic [net_id_width_gp-1:0] id);
        return pkt.net_id == id;
    endfunction

endpackage

// File: rtl/net_packet_decoder_if.sv
// Bundle of the decoder's network input and its imem / register-file / PC /
// barrier outputs; the decoder sits on the slave side.
interface net_packet_decoder_if #(
    parameter int imem_addr_width_p = 10
) ();
    import net_packet_decoder_pkg::*;

    net_packet_s                   net_packet_i;
    logic                          imem_ready_i;
    logic                          imem_wen_o;
    logic [imem_addr_width_p-1:0]  imem_addr_o;
    logic [instr_length-1:0]       imem_data_o;
    logic                          rf_wen_o;
    logic [rs_imm_size_gp-1:0]     rf_addr_o;
    logic [31:0]                   rf_data_o;
    logic                          pc_wen_o;
    logic [imem_addr_width_p-1:0]  pc_o;
    logic [mask_length_gp-1:0]     barrier_mask_o;
    logic                          run_o;
    logic                          error_o;

    modport master (
        output net_packet_i, imem_ready_i,
        input  imem_wen_o, imem_addr_o, imem_data_o,
        input  rf_wen_o, rf_addr_o, rf_data_o,
        input  pc_wen_o, pc_o, barrier_mask_o, run_o, error_o
    );

    modport slave (
        input  net_packet_i, imem_ready_i,
        output imem_wen_o, imem_addr_o, imem_data_o,
        output rf_wen_o, rf_addr_o, rf_data_o,
        output pc_wen_o, pc_o, barrier_mask_o, run_o, error_o
    );

endinterface

// File: rtl/net_decoder_fifo.sv
// Two-entry instruction FIFO; slot0 is always the head, so the head data
// keeps its last value once the FIFO has drained.
module net_decoder_fifo #(
    parameter int width_p = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    input  logic [width_p-1:0] wr_data,
    output logic               wr_ready,
    output logic               rd_valid,
    output logic [width_p-1:0] rd_data,
    input  logic               rd_ready,
    output logic               full,
    output logic               empty
);

    logic [1:0]         count;
    logic [width_p-1:0] slot0;
    logic [width_p-1:0] slot1;
    logic               push;
    logic               pop;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign rd_valid = !empty;
    assign rd_data  = slot0;
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot a push to a full FIFO needs.
    assign wr_ready = !full || pop;
    assign push     = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (empty) slot0 <= wr_data;
                    else       slot1 <= wr_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (full) slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (full) begin
                        slot0 <= slot1;
                        slot1 <= wr_data;
                    end else begin
                        slot0 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/net_packet_decoder.sv
// Decodes network packets into imem, register-file, start-PC and barrier writes.
// Define NET_ID_FILTER_EN to drop packets whose ID differs from core_id_p.
module net_packet_decoder
    import net_packet_decoder_pkg::*;
#(
    parameter logic [net_id_width_gp-1:0] core_id_p         = 10'd1,
    parameter int                         imem_addr_width_p = 10
) (
    input logic                 clk,
    input logic                 reset,
    net_packet_decoder_if.slave bus
);

    localparam int entry_width_lp = imem_addr_width_p + instr_length;

    decoder_state_e            state;
    decoder_state_e            next_state;
    net_packet_s               pkt_r;
    logic                      live;
    logic                      fifo_push;
    logic                      fifo_wr_ready;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_valid;
    logic [entry_width_lp-1:0] fifo_head;
    logic                      rf_we;
    logic                      pc_load;
    logic                      pc_fire;
    logic                      bar_load;
    logic                      err_set;
    logic                      unused_ok;

`ifdef NET_ID_FILTER_EN
    assign live      = (pkt_r.net_op != NULL) && id_matches(pkt_r, core_id_p);
    assign unused_ok = fifo_full;
`else
    assign live      = (pkt_r.net_op != NULL);
    assign unused_ok = ^{fifo_full, pkt_r.net_id, core_id_p};
`endif

    net_decoder_fifo #(.width_p(entry_width_lp)) fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (fifo_push),
        .wr_data  ({imem_addr_width_p'(pkt_r.net_addr), pkt_r.net_data[instr_length-1:0]}),
        .wr_ready (fifo_wr_ready),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_head),
        .rd_ready (bus.imem_ready_i),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.imem_wen_o                    = fifo_valid;
    assign {bus.imem_addr_o, bus.imem_data_o} = fifo_head;
    assign bus.run_o                         = (state == RUN);

    always_ff @(posedge clk) begin
        if (!reset) state <= HALT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        fifo_push  = 1'b0;
        rf_we      = 1'b0;
        pc_load    = 1'b0;
        pc_fire    = 1'b0;
        bar_load   = 1'b0;
        err_set    = 1'b0;
        case (state)
            HALT: begin
                if (live) begin
                    case (pkt_r.net_op)
                        INSTR: fifo_push = 1'b1;
                        REG:   rf_we     = 1'b1;
                        PC: begin
                            pc_load = 1'b1;
                            if (fifo_empty) begin
                                pc_fire    = 1'b1;
                                next_state = RUN;
                            end else begin
                                next_state = DRAIN;
                            end
                        end
                        BAR:     bar_load = 1'b1;
                        default: ;
                    endcase
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    pc_fire    = 1'b1;
                    next_state = RUN;
                end
                if (live) begin
                    if (pkt_r.net_op == BAR) bar_load = 1'b1;
                    else                     err_set  = 1'b1;
                end
            end
            RUN: begin
                if (live) begin
                    if (pkt_r.net_op == BAR) bar_load = 1'b1;
                    else                     err_set  = 1'b1;
                end
            end
            default: next_state = HALT;
        endcase
        if (fifo_push && !fifo_wr_ready) err_set = 1'b1;
    end

    // Every packet effect lands one edge after the packet is captured in pkt_r.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_r              <= '0;
            bus.rf_wen_o       <= 1'b0;
            bus.rf_addr_o      <= '0;
            bus.rf_data_o      <= '0;
            bus.pc_wen_o       <= 1'b0;
            bus.pc_o           <= '0;
            bus.barrier_mask_o <= '0;
            bus.error_o        <= 1'b0;
        end else begin
            pkt_r        <= bus.net_packet_i;
            bus.rf_wen_o <= rf_we;
            bus.pc_wen_o <= pc_fire;
            if (rf_we) begin
                bus.rf_addr_o <= pkt_r.net_addr[rs_imm_size_gp-1:0];
                bus.rf_data_o <= pkt_r.net_data;
            end
            if (pc_load)  bus.pc_o           <= pkt_r.net_data[imem_addr_width_p-1:0];
            if (bar_load) bus.barrier_mask_o <= pkt_r.net_data[mask_length_gp-1:0];
            if (err_set)  bus.error_o        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_net_packet_decoder.sv
// Scoreboard bench for net_packet_decoder: stimulus pushes expected writes,
// a negedge monitor pops and compares them as the DUT strobes its outputs.
module tb_net_packet_decoder;
    import net_packet_decoder_pkg::*;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
        int          cyc;
    } imem_exp_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } rf_exp_t;

    typedef struct {
        logic [9:0] value;
        int         cyc;
    } pc_exp_t;

    typedef enum {M_HALT, M_DRAIN, M_RUN} model_mode_e;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks     = 0;
    int   failures   = 0;
    int   pc_events  = 0;

    imem_exp_t imem_q[$];
    rf_exp_t   rf_q[$];
    pc_exp_t   pc_q[$];
    imem_exp_t imem_e;
    rf_exp_t   rf_e;
    pc_exp_t   pc_e;

    model_mode_e m_mode  = M_HALT;
    int          m_held  = 0;
    logic        m_error = 1'b0;
    logic [15:0] m_mask  = 16'h0;

    net_packet_decoder_if #(.imem_addr_width_p(10)) bus_if ();

    net_packet_decoder #(
        .core_id_p         (10'd1),
        .imem_addr_width_p (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Output monitor: each strobe consumes exactly one expected entry.
    always @(negedge clk) begin
        if (reset) begin
            if (bus_if.imem_wen_o && bus_if.imem_ready_i) begin
                if (imem_q.size() == 0) checkOutput("imem_unexpected", bus_if.imem_wen_o, 1'b0);
                else begin
                    imem_e = imem_q.pop_front();
                    checkOutput("imem_addr", bus_if.imem_addr_o, imem_e.addr);
                    checkOutput("imem_data", bus_if.imem_data_o, imem_e.data);
                    if (imem_e.cyc >= 0) checkOutput("imem_latency", cyc, imem_e.cyc);
                end
            end
            if (bus_if.rf_wen_o) begin
                if (rf_q.size() == 0) checkOutput("rf_unexpected", bus_if.rf_wen_o, 1'b0);
                else begin
                    rf_e = rf_q.pop_front();
                    checkOutput("rf_addr", bus_if.rf_addr_o, rf_e.addr);
                    checkOutput("rf_data", bus_if.rf_data_o, rf_e.data);
                    checkOutput("rf_latency", cyc, rf_e.cyc);
                end
            end
            if (bus_if.pc_wen_o) begin
                pc_events++;
                if (pc_q.size() == 0) checkOutput("pc_unexpected", bus_if.pc_wen_o, 1'b0);
                else begin
                    pc_e = pc_q.pop_front();
                    checkOutput("pc_value", bus_if.pc_o, pc_e.value);
                    checkOutput("pc_after_drain", imem_q.size(), 0);
                    checkOutput("run_with_pc", bus_if.run_o, 1'b1);
                    if (pc_e.cyc >= 0) checkOutput("pc_latency", cyc, pc_e.cyc);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic net_packet_s mkPkt(input logic [9:0] id, input net_op_e op,
                                          input logic [9:0] addr, input logic [31:0] data);
        net_packet_s p;
        p.net_id   = id;
        p.net_op   = op;
        p.net_addr = addr;
        p.net_data = data;
        return p;
    endfunction

    // Reference model: effect of one packet on the architectural view.
    task automatic modelPacket(input net_packet_s p);
        logic live;
        live = (p.net_op != NULL);
`ifdef NET_ID_FILTER_EN
        live = live && (p.net_id == 10'd1);
`endif
        if (!live) return;
        if (m_mode == M_HALT) begin
            case (p.net_op)
                INSTR: begin
                    if (bus_if.imem_ready_i) imem_q.push_back('{p.net_addr, p.net_data[15:0], cyc + 2});
                    else if (m_held < 2) begin
                        m_held++;
                        imem_q.push_back('{p.net_addr, p.net_data[15:0], -1});
                    end else m_error = 1'b1;
                end
                REG: rf_q.push_back('{p.net_addr[5:0], p.net_data, cyc + 2});
                PC: begin
                    if (m_held == 0) begin
                        pc_q.push_back('{p.net_data[9:0], cyc + 2});
                        m_mode = M_RUN;
                    end else begin
                        pc_q.push_back('{p.net_data[9:0], -1});
                        m_mode = M_DRAIN;
                    end
                end
                BAR: m_mask = p.net_data[15:0];
                default: ;
            endcase
        end else if (p.net_op == BAR) m_mask = p.net_data[15:0];
        else m_error = 1'b1;
    endtask

    task automatic applyStimulus(input net_packet_s p);
        modelPacket(p);
        bus_if.net_packet_i = p;
        step(1);
        bus_if.net_packet_i = '0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        bus_if.net_packet_i = mkPkt(10'd1, INSTR, 10'd7, 32'h1234);
        step(3);
        bus_if.net_packet_i = '0;
        checkOutput("rst_imem_wen", bus_if.imem_wen_o, 1'b0);
        checkOutput("rst_rf_wen", bus_if.rf_wen_o, 1'b0);
        checkOutput("rst_pc_wen", bus_if.pc_wen_o, 1'b0);
        checkOutput("rst_pc_o", bus_if.pc_o, 10'd0);
        checkOutput("rst_mask", bus_if.barrier_mask_o, 16'd0);
        checkOutput("rst_error", bus_if.error_o, 1'b0);
        checkOutput("rst_run", bus_if.run_o, 1'b0);
        imem_q.delete();
        rf_q.delete();
        pc_q.delete();
        m_mode  = M_HALT;
        m_held  = 0;
        m_error = 1'b0;
        m_mask  = 16'h0;
        reset = 1'b1;
        step(1);
    endtask

    task automatic waitPc();
        int start;
        int n;
        start = pc_events;
        n = 0;
        while (pc_events == start && n < 40) begin
            step(1);
            n++;
        end
        checkOutput("pc_wait", pc_events - start, 1);
        m_mode = M_RUN;
        m_held = 0;
    endtask

    initial begin
        net_op_e     op;
        logic [9:0]  id;
        bus_if.net_packet_i  = '0;
        bus_if.imem_ready_i  = 1'b1;
        step(1);
        doReset();
        step(2);
        checkOutput("imem_after_reset", bus_if.imem_wen_o, 1'b0);

        applyStimulus(mkPkt(10'd1, INSTR, 10'd3, 32'h0000A5C3));
        step(3);
        checkOutput("imem_idle", bus_if.imem_wen_o, 1'b0);

        applyStimulus(mkPkt(10'd1, REG, 10'd5, 32'hDEADBEEF));
        applyStimulus(mkPkt(10'd1, BAR, 10'd0, 32'h2));
        step(3);
        checkOutput("barrier_mask", bus_if.barrier_mask_o, 16'h2);
        checkOutput("rf_idle", bus_if.rf_wen_o, 1'b0);

`ifdef NET_ID_FILTER_EN
        applyStimulus(mkPkt(10'd2, REG, 10'd9, 32'h1111_1111));
        step(3);
        checkOutput("filter_error", bus_if.error_o, 1'b0);
        applyStimulus(mkPkt(10'd1, REG, 10'd9, 32'h2222_2222));
        step(3);
        checkOutput("filter_rf_left", rf_q.size(), 0);
`endif

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       op = NULL;
                1:       op = INSTR;
                2:       op = REG;
                default: op = BAR;
            endcase
`ifdef NET_ID_FILTER_EN
            id = 10'($urandom_range(1, 2));
`else
            id = 10'($urandom_range(0, 1023));
`endif
            applyStimulus(mkPkt(id, op, 10'($urandom_range(0, 1023)), $urandom()));
            step($urandom_range(0, 2));
        end
        step(4);
        checkOutput("rand_mask", bus_if.barrier_mask_o, m_mask);
        checkOutput("rand_error", bus_if.error_o, m_error);
        checkOutput("rand_imem_left", imem_q.size(), 0);
        checkOutput("rand_rf_left", rf_q.size(), 0);

        bus_if.imem_ready_i = 1'b0;
        applyStimulus(mkPkt(10'd1, INSTR, 10'd0, 32'h0000_1000));
        applyStimulus(mkPkt(10'd1, INSTR, 10'd1, 32'h0000_1001));
        applyStimulus(mkPkt(10'd1, INSTR, 10'd2, 32'h0000_1002));
        step(2);
        checkOutput("full_drop_error", bus_if.error_o, 1'b1);
        checkOutput("full_head_valid", bus_if.imem_wen_o, 1'b1);
        checkOutput("full_head_addr", bus_if.imem_addr_o, 10'd0);
        checkOutput("full_head_data", bus_if.imem_data_o, 16'h1000);

        doReset();
        bus_if.imem_ready_i = 1'b1;
        step(3);
        checkOutput("imem_flushed", bus_if.imem_wen_o, 1'b0);

        bus_if.imem_ready_i = 1'b0;
        applyStimulus(mkPkt(10'd1, INSTR, 10'h10, 32'h0000_BEE0));
        applyStimulus(mkPkt(10'd1, INSTR, 10'h11, 32'h0000_BEE1));
        applyStimulus(mkPkt(10'd1, PC, 10'd0, 32'd5));
        step(3);
        checkOutput("drain_run", bus_if.run_o, 1'b0);
        checkOutput("drain_error", bus_if.error_o, m_error);
        checkOutput("drain_pc_wen", bus_if.pc_wen_o, 1'b0);
        bus_if.imem_ready_i = 1'b1;
        waitPc();
        step(1);
        checkOutput("run_after_drain", bus_if.run_o, 1'b1);
        checkOutput("pc_hold", bus_if.pc_o, 10'd5);
        checkOutput("drain_pc_wen_low", bus_if.pc_wen_o, 1'b0);

        applyStimulus(mkPkt(10'd1, REG, 10'd3, 32'hCAFE_F00D));
        applyStimulus(mkPkt(10'd1, INSTR, 10'd4, 32'h0000_7777));
        applyStimulus(mkPkt(10'd1, BAR, 10'd0, 32'h7));
        step(3);
        checkOutput("run_error", bus_if.error_o, m_error);
        checkOutput("run_mask", bus_if.barrier_mask_o, 16'h7);
        checkOutput("run_stays", bus_if.run_o, 1'b1);

        doReset();
        applyStimulus(mkPkt(10'd1, PC, 10'd0, 32'd9));
        step(3);
        checkOutput("direct_run", bus_if.run_o, 1'b1);
        checkOutput("direct_pc", bus_if.pc_o, 10'd9);
        checkOutput("end_pc_left", pc_q.size(), 0);
        checkOutput("end_imem_left", imem_q.size(), 0);
        checkOutput("end_rf_left", rf_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
